instr_fetch_stage: RTL and testbench

- Producer end of the valid/ready instruction handshake into the controller pipeline.
- Generates the PC and issues reads to code memory, which has a fixed 1-cycle read latency.
- Captures returned instructions into a 2-entry output buffer and presents them downstream with vld/next_rdy, a per-instruction pipeline cycle count and the instruction's address.
- On branch_mispredict, redirects to branch_target and discards all fetched-but-unconsumed work.

---
 rtl/instr_fetch_stage_pkg.sv | 14 +
 rtl/instr_fetch_stage_skid_buf.sv | 92 +++++++++
 rtl/instr_fetch_stage.sv | 89 ++++++++
 tb/tb_instr_fetch_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared defaults for the fetch stage and its output buffer.
package instr_fetch_stage_pkg;

  localparam int CODE_ADDR_WIDTH_DEF = 10;
  localparam int INSTR_WIDTH_DEF     = 64;
  localparam int COUNT_WIDTH_DEF     = 6;

  // Output buffer depth; the issue credit check in the top relies on this.
  localparam int FETCH_BUF_DEPTH = 2;

  // Occupancy of the output buffer, 0..FETCH_BUF_DEPTH.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/instr_fetch_stage_skid_buf.sv
// Two-entry in-order buffer of {instr, pc, count}. Entry 0 is always the head.
// Each entry has its own saturating cycle counter.
module fetch_skid_buf
  import instr_fetch_stage_pkg::*;
#(
  parameter int IW = INSTR_WIDTH_DEF,
  parameter int AW = CODE_ADDR_WIDTH_DEF,
  parameter int CW = COUNT_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [IW-1:0] push_instr,
  input  logic [AW-1:0] push_pc,
  input  logic          pop,
  input  logic          flush,
  input  logic          cnt_en,
  output logic [IW-1:0] head_instr,
  output logic [AW-1:0] head_pc,
  output logic [CW-1:0] head_cnt,
  output occ_t          occ,
  output logic          vld
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [IW-1:0] instr_q [2];
  logic [IW-1:0] instr_n [2];
  logic [AW-1:0] pc_q    [2];
  logic [AW-1:0] pc_n    [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_n   [2];
  logic [CW-1:0] cnt_inc [2];
  occ_t          occ_q;
  occ_t          occ_n;
  occ_t          occ_after_pop;
  logic          pop_eff;
  logic          wr_idx;

  // Next-state: age counters, shift on pop, write the new entry behind the
  // surviving ones. Flush wins over push and pop.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = (cnt_en && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_ONE : cnt_q[i];
    end
    instr_n       = instr_q;
    pc_n          = pc_q;
    cnt_n         = cnt_inc;
    pop_eff       = pop && (occ_q != 2'd0);
    occ_after_pop = occ_q - {1'b0, pop_eff};
    wr_idx        = (occ_after_pop != 2'd0);
    if (pop_eff) begin
      instr_n[0] = instr_q[1];
      pc_n[0]    = pc_q[1];
      cnt_n[0]   = cnt_inc[1];
    end
    if (push) begin
      instr_n[wr_idx] = push_instr;
      pc_n[wr_idx]    = push_pc;
      cnt_n[wr_idx]   = CNT_ONE;
    end
    occ_n = occ_after_pop + {1'b0, push};
    if (flush) begin
      occ_n = 2'd0;
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
      occ_q <= 2'd0;
    end else begin
      instr_q <= instr_n;
      pc_q    <= pc_n;
      cnt_q   <= cnt_n;
      occ_q   <= occ_n;
    end
  end

  assign head_instr = instr_q[0];
  assign head_pc    = pc_q[0];
  assign head_cnt   = cnt_q[0];
  assign occ        = occ_q;
  assign vld        = (occ_q != 2'd0);

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC generation, 1-cycle-latency code memory reads,
// and a 2-entry output buffer feeding the controller pipeline.
//
// Handshake: an instruction transfers downstream on any cycle where
// vld && next_rdy at the rising edge. While vld is high and next_rdy is low,
// instr_out/pc_out hold steady (ocount may still advance with PC_en).
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int CODE_ADDR_WIDTH = CODE_ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH     = INSTR_WIDTH_DEF,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  input  logic                       branch_mispredict,
  input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
  input  logic                       PC_en,
  output logic                       code_rd_en,
  output logic [CODE_ADDR_WIDTH-1:0] code_rd_addr,
  input  logic [INSTR_WIDTH-1:0]     code_rd_data,
  output logic [INSTR_WIDTH-1:0]     instr_out,
  output logic [CODE_ADDR_WIDTH-1:0] pc_out,
  output logic [COUNT_WIDTH-1:0]     ocount,
  output logic                       vld,
  input  logic                       next_rdy
);

  logic [CODE_ADDR_WIDTH-1:0] pc_q;
  logic [CODE_ADDR_WIDTH-1:0] inflight_pc_q;
  logic                       inflight_q;
  occ_t                       occ;
  logic                       pop;
  logic [2:0]                 credit_used;
  logic                       has_room;

  assign pop = vld && next_rdy;

  // Credit check: buffered + in-flight words, less this cycle's pop, must
  // leave a free slot for the word being requested now.
  always_comb begin
    credit_used = {1'b0, occ} + {2'b00, inflight_q};
    has_room    = credit_used < (3'(FETCH_BUF_DEPTH) + {2'b00, pop});
  end

  // Reads are suppressed while reset is held so the strobe drops immediately.
  assign code_rd_en   = !rst && fetch_en && !branch_mispredict && has_room;
  assign code_rd_addr = pc_q;

  // PC and in-flight tracking; a mispredict redirects and cancels the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (branch_mispredict) begin
      pc_q       <= branch_target;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= code_rd_en;
      if (code_rd_en) begin
        pc_q          <= pc_q + CODE_ADDR_WIDTH'(1);
        inflight_pc_q <= pc_q;
      end
    end
  end

  fetch_skid_buf #(
    .IW (INSTR_WIDTH),
    .AW (CODE_ADDR_WIDTH),
    .CW (COUNT_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q && !branch_mispredict),
    .push_instr (code_rd_data),
    .push_pc    (inflight_pc_q),
    .pop        (pop),
    .flush      (branch_mispredict),
    .cnt_en     (PC_en),
    .head_instr (instr_out),
    .head_pc    (pc_out),
    .head_cnt   (ocount),
    .occ        (occ),
    .vld        (vld)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a 1-cycle-latency code memory model.
module tb_instr_fetch_stage;

  localparam int AW = 10;
  localparam int IW = 64;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          branch_mispredict;
  logic [AW-1:0] branch_target;
  logic          PC_en;
  logic          code_rd_en;
  logic [AW-1:0] code_rd_addr;
  logic [IW-1:0] code_rd_data;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic [CW-1:0] ocount;
  logic          vld;
  logic          next_rdy;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  instr_fetch_stage #(
    .CODE_ADDR_WIDTH (AW),
    .INSTR_WIDTH     (IW),
    .COUNT_WIDTH     (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_en          (fetch_en),
    .branch_mispredict (branch_mispredict),
    .branch_target     (branch_target),
    .PC_en             (PC_en),
    .code_rd_en        (code_rd_en),
    .code_rd_addr      (code_rd_addr),
    .code_rd_data      (code_rd_data),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .ocount            (ocount),
    .vld               (vld),
    .next_rdy          (next_rdy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address a is a << 8
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    logic [IW-1:0] w;
    w = '0;
    w[AW-1:0] = a;
    return w << 8;
  endfunction

  // Code memory with 1-cycle read latency
  always @(posedge clk) begin
    if (code_rd_en) code_rd_data <= mem_word(code_rd_addr);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    branch_mispredict = 1'b0;
    branch_target = '0;
    PC_en = 1'b0;
    next_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic stream_on();
    fetch_en = 1'b1;
    next_rdy = 1'b1;
    PC_en = 1'b1;
    #1;
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    code_rd_data = '0;
    // Reset state
    rst = 1'b1;
    fetch_en = 1'b1;
    branch_mispredict = 1'b0;
    branch_target = '0;
    PC_en = 1'b1;
    next_rdy = 1'b1;
    #3;
    check("rst_vld", vld, 0);
    check("rst_instr", instr_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_cnt", ocount, 0);
    check("rst_rd_en", code_rd_en, 0);
    check("rst_rd_addr", code_rd_addr, 0);

    // 1. Streaming
    do_reset();
    stream_on();
    check("t1_c0_rd_en", code_rd_en, 1);
    check("t1_c0_addr", code_rd_addr, 0);
    check("t1_c0_vld", vld, 0);
    tick(); #1;
    check("t1_c1_addr", code_rd_addr, 1);
    check("t1_c1_vld", vld, 0);
    for (int k = 2; k < 8; k++) begin
      tick(); #1;
      check("t1_vld", vld, 1);
      check("t1_pc", pc_out, 64'(k - 2));
      check("t1_instr", instr_out, mem_word(AW'(k - 2)));
      check("t1_cnt", ocount, 1);
      check("t1_addr", code_rd_addr, 64'(k));
    end

    // 2. Backpressure
    do_reset();
    stream_on();
    tick(); tick(); #1;
    check("t2_c2_pc", pc_out, 0);
    tick();
    next_rdy = 1'b0;
    #1;
    check("t2_c3_pc", pc_out, 1);
    check("t2_c3_cnt", ocount, 1);
    check("t2_c3_rd_en", code_rd_en, 0);
    for (int k = 4; k < 8; k++) begin
      tick(); #1;
      check("t2_hold_vld", vld, 1);
      check("t2_hold_pc", pc_out, 1);
      check("t2_hold_cnt", ocount, 64'(k - 2));
      check("t2_hold_rd_en", code_rd_en, 0);
    end
    tick();
    next_rdy = 1'b1;
    #1;
    check("t2_c8_cnt", ocount, 6);
    check("t2_c8_rd_en", code_rd_en, 1);
    check("t2_c8_addr", code_rd_addr, 3);
    for (int p = 1; p <= 6; p++) exp_q.push_back(64'(p));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      if (vld) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("t2_order", pc_out, e);
        if (e == 2) check("t2_pc2_cnt", ocount, 6);
      end
      tick(); #1;
    end
    check("t2_drained", exp_q.size(), 0);

    // 3. Mispredict with a read in flight
    do_reset();
    stream_on();
    tick(); tick(); tick(); tick();
    branch_mispredict = 1'b1;
    branch_target = 10'h2A;
    #1;
    check("t3_pop_vld", vld, 1);
    check("t3_pop_pc", pc_out, 2);
    check("t3_mp_rd_en", code_rd_en, 0);
    tick();
    branch_mispredict = 1'b0;
    #1;
    check("t3_flush_vld", vld, 0);
    check("t3_redirect_en", code_rd_en, 1);
    check("t3_redirect_addr", code_rd_addr, 10'h2A);
    tick(); #1;
    check("t3_c6_vld", vld, 0);
    check("t3_c6_addr", code_rd_addr, 10'h2B);
    tick(); #1;
    check("t3_first_vld", vld, 1);
    check("t3_first_pc", pc_out, 10'h2A);
    check("t3_first_instr", instr_out, mem_word(10'h2A));

    // 4. PC wrap and count saturation
    tick();
    branch_mispredict = 1'b1;
    branch_target = 10'h3FE;
    #1;
    check("t4_mp_rd_en", code_rd_en, 0);
    tick();
    branch_mispredict = 1'b0;
    #1;
    check("t4_addr_3fe", code_rd_addr, 10'h3FE);
    check("t4_vld0", vld, 0);
    tick(); #1;
    check("t4_addr_3ff", code_rd_addr, 10'h3FF);
    tick(); #1;
    check("t4_addr_wrap", code_rd_addr, 0);
    check("t4_wrap_en", code_rd_en, 1);
    check("t4_pc_3fe", pc_out, 10'h3FE);
    tick();
    next_rdy = 1'b0;
    #1;
    check("t4_pc_3ff", pc_out, 10'h3FF);
    check("t4_cnt1", ocount, 1);
    check("t4_full_rd_en", code_rd_en, 0);
    for (int i = 1; i <= 70; i++) begin
      tick(); #1;
      if (i == 61) check("t4_cnt62", ocount, 62);
    end
    check("t4_cnt_sat", ocount, 63);
    check("t4_sat_pc", pc_out, 10'h3FF);
    check("t4_sat_vld", vld, 1);

    // 5. Asynchronous reset between edges with a full buffer
    #2;
    rst = 1'b1;
    #1;
    check("t5_vld", vld, 0);
    check("t5_cnt", ocount, 0);
    check("t5_rd_en", code_rd_en, 0);
    check("t5_pc", pc_out, 0);
    #1;
    rst = 1'b0;
    next_rdy = 1'b1;
    #1;
    check("t5_restart_en", code_rd_en, 1);
    check("t5_restart_addr", code_rd_addr, 0);
    tick(); tick(); #1;
    check("t5_first_vld", vld, 1);
    check("t5_first_pc", pc_out, 0);
    check("t5_first_instr", instr_out, mem_word(0));

    // 6. fetch_en dropped right after an issue
    do_reset();
    stream_on();
    check("t6_c0_en", code_rd_en, 1);
    tick();
    fetch_en = 1'b0;
    #1;
    check("t6_c1_en", code_rd_en, 0);
    tick();
    next_rdy = 1'b0;
    PC_en = 1'b0;
    #1;
    check("t6_c2_vld", vld, 1);
    check("t6_c2_pc", pc_out, 0);
    check("t6_c2_en", code_rd_en, 0);
    tick(); #1;
    check("t6_c3_cnt_hold", ocount, 1);
    check("t6_c3_en", code_rd_en, 0);
    tick();
    fetch_en = 1'b1;
    next_rdy = 1'b1;
    PC_en = 1'b1;
    #1;
    check("t6_c4_en", code_rd_en, 1);
    check("t6_c4_addr", code_rd_addr, 1);
    check("t6_c4_pc", pc_out, 0);
    tick(); #1;
    check("t6_c5_vld", vld, 0);
    check("t6_c5_addr", code_rd_addr, 2);
    tick(); #1;
    check("t6_c6_vld", vld, 1);
    check("t6_c6_pc", pc_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
